// File: rtl/mult_div_unit_pkg.sv
// mult_div_unit_pkg
// Shared definitions for the multiply/divide unit: MDU opcode encodings,
// the FSM state type and small opcode classification helpers.
// No ports (package).

package mult_div_unit_pkg;

   // MDU opcode encodings carried on MDUOp; 0 means "no MDU activity".
   localparam logic [3:0] MDU_NOP   = 4'd0;
   localparam logic [3:0] MDU_MULT  = 4'd1;
   localparam logic [3:0] MDU_MULTU = 4'd2;
   localparam logic [3:0] MDU_DIV   = 4'd3;
   localparam logic [3:0] MDU_DIVU  = 4'd4;
   localparam logic [3:0] MDU_MTHI  = 4'd5;
   localparam logic [3:0] MDU_MTLO  = 4'd6;
   localparam logic [3:0] MDU_MFHI  = 4'd7;
   localparam logic [3:0] MDU_MFLO  = 4'd8;

   typedef enum logic {
      MDU_IDLE = 1'b0,
      MDU_BUSY = 1'b1
   } mdu_state_e;

   // True for the opcodes that occupy the unit for several cycles.
   function automatic logic is_arith_op(input logic [3:0] op);
      return (op == MDU_MULT) || (op == MDU_MULTU) ||
             (op == MDU_DIV)  || (op == MDU_DIVU);
   endfunction

   // Selects the multiply latency rather than the divide latency.
   function automatic logic is_mul_op(input logic [3:0] op);
      return (op == MDU_MULT) || (op == MDU_MULTU);
   endfunction

endpackage

// File: rtl/mult_div_unit_core.sv
// mult_div_unit_core
// Purely combinational arithmetic of the MDU: produces the {hi, lo} pair
// for MULT/MULTU/DIV/DIVU from the latched opcode and operands, including
// the divide-by-zero and signed-overflow results.
// Ports:
//   op  in  4      latched MDU opcode
//   a   in  WIDTH  multiplicand / dividend
//   b   in  WIDTH  multiplier / divisor
//   hi  out WIDTH  upper product half or remainder
//   lo  out WIDTH  lower product half or quotient

module mult_div_unit_core
   import mult_div_unit_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

   logic                    div_by_zero;
   logic                    div_overflow;
   logic [2*WIDTH-1:0]      prod_s;
   logic [2*WIDTH-1:0]      prod_u;
   logic signed [WIDTH-1:0] quot_s;
   logic signed [WIDTH-1:0] rem_s;
   logic [WIDTH-1:0]        quot_u;
   logic [WIDTH-1:0]        rem_u;

   // Products are formed at full 2W width by extending the operands first.
   // The dividers are only exercised when the divisor is legal, so the
   // special cases below never depend on what a raw x/0 would produce.
   always_comb begin
      div_by_zero  = (b == '0);
      div_overflow = (a == MIN_NEG) && (b == '1);

      prod_s = $signed({{WIDTH{a[WIDTH-1]}}, a}) * $signed({{WIDTH{b[WIDTH-1]}}, b});
      prod_u = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};

      quot_s = '0;
      rem_s  = '0;
      quot_u = '0;
      rem_u  = '0;
      if (!div_by_zero) begin
         quot_u = a / b;
         rem_u  = a % b;
         if (!div_overflow) begin
            quot_s = $signed(a) / $signed(b);
            rem_s  = $signed(a) % $signed(b);
         end
      end

      hi = '0;
      lo = '0;
      case (op)
         MDU_MULT:  {hi, lo} = prod_s;
         MDU_MULTU: {hi, lo} = prod_u;
         MDU_DIV: begin
            if (div_by_zero) begin
               hi = a;
               lo = '1;
            end else if (div_overflow) begin
               hi = '0;
               lo = a;
            end else begin
               hi = rem_s;
               lo = quot_s;
            end
         end
         MDU_DIVU: begin
            if (div_by_zero) begin
               hi = a;
               lo = '1;
            end else begin
               hi = rem_u;
               lo = quot_u;
            end
         end
         default: begin
            hi = '0;
            lo = '0;
         end
      endcase
   end

endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
// Launches MULT/MULTU/DIV/DIVU on MDUStart, stays busy for a fixed latency,
// then commits the result; also handles MTHI/MTLO writes and MFHI/MFLO reads.
// Ports:
//   clk        in   1      rising-edge clock
//   reset      in   1      asynchronous active-low reset
//   MDUStart   in   1      launch pulse for an arithmetic MDUOp
//   MDUOp      in   4      MDU opcode (see mult_div_unit_pkg)
//   MDUSrcA    in   WIDTH  rs operand / MTHI-MTLO data
//   MDUSrcB    in   WIDTH  rt operand
//   MDUBusy    out  1      registered, high while an operation is in flight
//   MDUResult  out  WIDTH  HI for MFHI, LO for MFLO, otherwise 0
//   HI, LO     out  WIDTH  architectural registers

module mult_div_unit
   import mult_div_unit_pkg::*;
#(
   parameter int WIDTH      = 32,
   parameter int MUL_CYCLES = 5,
   parameter int DIV_CYCLES = 10
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             MDUStart,
   input  logic [3:0]       MDUOp,
   input  logic [WIDTH-1:0] MDUSrcA,
   input  logic [WIDTH-1:0] MDUSrcB,
   output logic             MDUBusy,
   output logic [WIDTH-1:0] MDUResult,
   output logic [WIDTH-1:0] HI,
   output logic [WIDTH-1:0] LO
);

   localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
   localparam int CNT_W      = $clog2(MAX_CYCLES) + 1;
   localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES);
   localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);

   mdu_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [3:0]       op_q, op_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic             busy_q, busy_d;
   logic [WIDTH-1:0] core_hi;
   logic [WIDTH-1:0] core_lo;

   // The core only ever sees the latched operands, so the pipeline is free
   // to change MDUSrcA/B while the unit is busy.
   mult_div_unit_core #(
      .WIDTH (WIDTH)
   ) u_core (
      .op (op_q),
      .a  (a_q),
      .b  (b_q),
      .hi (core_hi),
      .lo (core_lo)
   );

   // Next-state logic. In IDLE an arithmetic start wins; otherwise MTHI/MTLO
   // write the register regardless of MDUStart. In BUSY every input is
   // ignored and the counter runs down to the commit edge at count 1.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      op_d    = op_q;
      a_d     = a_q;
      b_d     = b_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      busy_d  = busy_q;
      case (state_q)
         MDU_IDLE: begin
            if (MDUStart && is_arith_op(MDUOp)) begin
               state_d = MDU_BUSY;
               op_d    = MDUOp;
               a_d     = MDUSrcA;
               b_d     = MDUSrcB;
               cnt_d   = is_mul_op(MDUOp) ? MUL_LOAD : DIV_LOAD;
               busy_d  = 1'b1;
            end else if (MDUOp == MDU_MTHI) begin
               hi_d = MDUSrcA;
            end else if (MDUOp == MDU_MTLO) begin
               lo_d = MDUSrcA;
            end
         end
         MDU_BUSY: begin
            if (cnt_q == CNT_LAST) begin
               hi_d    = core_hi;
               lo_d    = core_lo;
               busy_d  = 1'b0;
               cnt_d   = '0;
               state_d = MDU_IDLE;
            end else begin
               cnt_d = cnt_q - CNT_LAST;
            end
         end
         default: begin
            state_d = MDU_IDLE;
            busy_d  = 1'b0;
            cnt_d   = '0;
         end
      endcase
   end

   // State, counter, operand latches and HI/LO; reset discards any op in flight.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= MDU_IDLE;
         cnt_q   <= '0;
         op_q    <= MDU_NOP;
         a_q     <= '0;
         b_q     <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         a_q     <= a_d;
         b_q     <= b_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         busy_q  <= busy_d;
      end
   end

   // MFHI/MFLO read the committed registers, so during BUSY they still
   // return the values from before the operation started.
   always_comb begin
      MDUResult = '0;
      if (MDUOp == MDU_MFHI) begin
         MDUResult = hi_q;
      end else if (MDUOp == MDU_MFLO) begin
         MDUResult = lo_q;
      end
   end

   assign MDUBusy = busy_q;
   assign HI      = hi_q;
   assign LO      = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit
// Self-checking bench for mult_div_unit: directed corner cases plus a
// randomized sequence of MDU operations compared against an arithmetic
// reference model of HI/LO and the busy latency.

module tb_mult_div_unit;
   import mult_div_unit_pkg::*;

   localparam int W    = 32;
   localparam int MULC = 5;
   localparam int DIVC = 10;

   logic         clk = 1'b0;
   logic         reset;
   logic         MDUStart;
   logic [3:0]   MDUOp;
   logic [W-1:0] MDUSrcA;
   logic [W-1:0] MDUSrcB;
   logic         MDUBusy;
   logic [W-1:0] MDUResult;
   logic [W-1:0] HI;
   logic [W-1:0] LO;

   int           testsRun    = 0;
   int           testsFailed = 0;
   logic [W-1:0] expHi = '0;
   logic [W-1:0] expLo = '0;

   mult_div_unit #(
      .WIDTH      (W),
      .MUL_CYCLES (MULC),
      .DIV_CYCLES (DIVC)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .MDUStart  (MDUStart),
      .MDUOp     (MDUOp),
      .MDUSrcA   (MDUSrcA),
      .MDUSrcB   (MDUSrcB),
      .MDUBusy   (MDUBusy),
      .MDUResult (MDUResult),
      .HI        (HI),
      .LO        (LO)
   );

   // Free-running 100 MHz clock.
   always #5 clk = ~clk;

   // Safety net so a stuck MDUBusy can never hang the run.
   initial begin
      #300000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      testsRun++;
      if (observed !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
      end
   endtask

   // Reference arithmetic: returns {hi, lo} from plain integer maths on
   // magnitudes, with divide-by-zero handled as an explicit rule.
   function automatic logic [63:0] refModel(input logic [3:0] op,
                                            input logic [W-1:0] a,
                                            input logic [W-1:0] b);
      longint       sa, sb, magA, magB, q, r;
      logic [63:0]  ua, ub, qv, rv;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = {32'b0, a};
      ub = {32'b0, b};
      case (op)
         MDU_MULT:  return 64'(sa * sb);
         MDU_MULTU: return ua * ub;
         MDU_DIVU: begin
            if (b == 0) return {a, 32'hFFFF_FFFF};
            qv = ua / ub;
            rv = ua % ub;
            return {rv[31:0], qv[31:0]};
         end
         MDU_DIV: begin
            if (b == 0) return {a, 32'hFFFF_FFFF};
            magA = (sa < 0) ? -sa : sa;
            magB = (sb < 0) ? -sb : sb;
            q = magA / magB;
            r = magA % magB;
            if ((sa < 0) != (sb < 0)) q = -q;
            if (sa < 0) r = -r;
            qv = 64'(q);
            rv = 64'(r);
            return {rv[31:0], qv[31:0]};
         end
         default: return {expHi, expLo};
      endcase
   endfunction

   // Reads HI/LO back both through MFHI/MFLO and the observe ports.
   task automatic readBack(input string tag);
      MDUOp = MDU_MFHI;
      #1;
      checkOutput({tag, " MFHI"}, MDUResult, expHi);
      MDUOp = MDU_MFLO;
      #1;
      checkOutput({tag, " MFLO"}, MDUResult, expLo);
      MDUOp = MDU_NOP;
      #1;
      checkOutput({tag, " result NOP"}, MDUResult, 0);
      checkOutput({tag, " HI"}, HI, expHi);
      checkOutput({tag, " LO"}, LO, expLo);
   endtask

   // Launches one arithmetic op, pokes ignored traffic at the unit while it
   // is busy, then checks the busy length and the committed HI/LO.
   task automatic applyStimulus(input string tag, input logic [3:0] op,
                                input logic [W-1:0] a, input logic [W-1:0] b);
      int cycles;
      int wantCycles;
      wantCycles = is_mul_op(op) ? MULC : DIVC;
      @(negedge clk);
      MDUOp    = op;
      MDUSrcA  = a;
      MDUSrcB  = b;
      MDUStart = 1'b1;
      @(negedge clk);
      MDUStart = 1'b0;
      MDUOp    = MDU_NOP;
      cycles   = 0;
      while (MDUBusy === 1'b1 && cycles < 50) begin
         cycles++;
         MDUSrcA = $urandom;
         MDUSrcB = $urandom;
         case ($urandom_range(0, 3))
            0: begin
               MDUOp = MDU_MFHI;
               #1;
               checkOutput({tag, " busy MFHI old"}, MDUResult, expHi);
            end
            1: MDUOp = MDU_MTLO;
            2: begin
               MDUOp    = MDU_MTHI;
               MDUStart = 1'b1;
            end
            default: begin
               MDUOp    = MDU_MULT;
               MDUStart = 1'b1;
            end
         endcase
         @(negedge clk);
         MDUStart = 1'b0;
         MDUOp    = MDU_NOP;
      end
      checkOutput({tag, " busy cycles"}, cycles, wantCycles);
      {expHi, expLo} = refModel(op, a, b);
      readBack(tag);
   endtask

   // MTHI/MTLO in IDLE, with MDUStart randomly asserted to show it is ignored.
   task automatic writeReg(input string tag, input logic [3:0] op,
                           input logic [W-1:0] data);
      @(negedge clk);
      MDUOp    = op;
      MDUSrcA  = data;
      MDUSrcB  = $urandom;
      MDUStart = 1'($urandom_range(0, 1));
      @(negedge clk);
      MDUOp    = MDU_NOP;
      MDUStart = 1'b0;
      if (op == MDU_MTHI) expHi = data;
      else                expLo = data;
      checkOutput({tag, " busy"}, MDUBusy, 1'b0);
      readBack(tag);
   endtask

   function automatic logic [W-1:0] pickOperand();
      case ($urandom_range(0, 6))
         0:       return '0;
         1:       return 32'h8000_0000;
         2:       return '1;
         3:       return W'($urandom_range(0, 20));
         default: return W'($urandom);
      endcase
   endfunction

   initial begin
      logic [3:0]   rop;
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      reset    = 1'b0;
      MDUStart = 1'b0;
      MDUOp    = MDU_NOP;
      MDUSrcA  = '0;
      MDUSrcB  = '0;
      #2;
      checkOutput("reset busy", MDUBusy, 1'b0);
      checkOutput("reset HI", HI, 0);
      checkOutput("reset LO", LO, 0);

      // A start presented while reset is still low must not launch.
      @(negedge clk);
      MDUOp    = MDU_MULT;
      MDUSrcA  = 32'd3;
      MDUSrcB  = 32'd4;
      MDUStart = 1'b1;
      @(negedge clk);
      checkOutput("start under reset", MDUBusy, 1'b0);
      MDUStart = 1'b0;
      MDUOp    = MDU_NOP;
      reset    = 1'b1;

      applyStimulus("mult neg", MDU_MULT, 32'hFFFF_FFFE, 32'd3);
      checkOutput("mult neg HI const", HI, 32'hFFFF_FFFF);
      checkOutput("mult neg LO const", LO, 32'hFFFF_FFFA);
      applyStimulus("multu", MDU_MULTU, 32'hFFFF_FFFF, 32'd2);
      checkOutput("multu HI const", HI, 32'd1);
      checkOutput("multu LO const", LO, 32'hFFFF_FFFE);
      applyStimulus("div neg", MDU_DIV, -32'sd7, 32'd2);
      checkOutput("div neg LO const", LO, 32'hFFFF_FFFD);
      checkOutput("div neg HI const", HI, 32'hFFFF_FFFF);
      applyStimulus("divu", MDU_DIVU, 32'd7, 32'd2);
      applyStimulus("div by zero", MDU_DIV, 32'd5, 32'd0);
      checkOutput("div0 LO const", LO, 32'hFFFF_FFFF);
      checkOutput("div0 HI const", HI, 32'd5);
      applyStimulus("divu by zero", MDU_DIVU, 32'hDEAD_BEEF, 32'd0);
      applyStimulus("div overflow", MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
      checkOutput("ovf LO const", LO, 32'h8000_0000);
      checkOutput("ovf HI const", HI, 32'd0);
      writeReg("mthi", MDU_MTHI, 32'h1234);
      writeReg("mtlo", MDU_MTLO, 32'hCAFE_0001);

      // Reset pulled low in the fourth busy cycle of a divide.
      @(negedge clk);
      MDUOp    = MDU_DIV;
      MDUSrcA  = 32'd100;
      MDUSrcB  = 32'd7;
      MDUStart = 1'b1;
      @(negedge clk);
      MDUStart = 1'b0;
      MDUOp    = MDU_NOP;
      repeat (3) @(negedge clk);
      #2;
      reset = 1'b0;
      #1;
      checkOutput("mid-div reset busy", MDUBusy, 1'b0);
      checkOutput("mid-div reset HI", HI, 0);
      checkOutput("mid-div reset LO", LO, 0);
      expHi = '0;
      expLo = '0;
      @(negedge clk);
      reset = 1'b1;
      applyStimulus("after reset", MDU_DIV, 32'd100, 32'd7);

      // Randomized mix of arithmetic and register moves.
      for (int i = 0; i < 40; i++) begin
         ra = pickOperand();
         rb = pickOperand();
         case ($urandom_range(0, 5))
            0: rop = MDU_MULT;
            1: rop = MDU_MULTU;
            2: rop = MDU_DIV;
            3: rop = MDU_DIVU;
            4: rop = MDU_MTHI;
            default: rop = MDU_MTLO;
         endcase
         if (is_arith_op(rop)) applyStimulus("random op", rop, ra, rb);
         else                  writeReg("random move", rop, ra);
      end

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
